// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern-detection run controller:
// FSM state encoding, default pattern and small state helpers.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int              DEF_PAT_W   = 4;
    localparam logic [3:0]      DEF_RST_PAT = 4'b0101;

    function automatic logic is_busy(input state_t s);
        return (s == ARM) || (s == RUN);
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Serial matcher: keeps the last PAT_W-1 valid bits and how many have been
// collected since the last clear, and flags a full-window match on the current bit.
module seq_det_match #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             din,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit,
    output logic             full
);

    localparam int FILL_W = $clog2(PAT_W) + 1;

    logic [PAT_W-2:0]  sh;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;

    // Oldest bit lands in the MSB, matching the pattern's bit ordering.
    assign window = {sh, din};
    assign full   = (fill == FILL_W'(PAT_W - 1));
    assign hit    = en & din_valid & full & (window == pattern);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh   <= '0;
            fill <= '0;
        end else if (clear) begin
            sh   <= '0;
            fill <= '0;
        end else if (en && din_valid) begin
            sh <= window[PAT_W-2:0];
            if (!full)
                fill <= fill + FILL_W'(1);
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-control sequencer: holds the configuration, arms detection on start,
// counts matches and ends a run on target count, timeout or abort.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter int               TMO_W   = 16,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             tmo
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pattern_q;
    logic [CNT_W-1:0] target_q;
    logic [TMO_W-1:0] timeout_q;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;

    logic start_ok;
    logic hit, full;
    logic tgt_hit, tmo_hit;
    logic cnt_en, z_nxt, done_nxt, tmo_set;

    assign busy        = is_busy(state);
    assign start_ok    = start & ~busy;
    assign tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
    assign tgt_hit     = hit && (target_q != '0) && ((match_cnt + CNT_W'(1)) == target_q);
    assign tmo_hit     = busy && (timeout_q != '0) && (tmo_cnt_nxt == timeout_q);

    seq_det_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .en        (busy),
        .din       (din),
        .din_valid (din_valid),
        .pattern   (pattern_q),
        .hit       (hit),
        .full      (full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Abort outranks target, target outranks timeout; a match on an abort edge is dropped.
    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        z_nxt     = 1'b0;
        done_nxt  = 1'b0;
        tmo_set   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = ARM;
            end
            ARM, RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_en = hit;
                    z_nxt  = hit;
                    if (tgt_hit) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (tmo_hit) begin
                        state_nxt = DONE;
                        tmo_set   = 1'b1;
                    end else if (state == ARM && full && din_valid) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= RST_PAT;
            target_q  <= '0;
            timeout_q <= '0;
            match_cnt <= '0;
            tmo_cnt   <= '0;
            z         <= 1'b0;
            done      <= 1'b0;
            tmo       <= 1'b0;
        end else begin
            if (cfg_we && !busy) begin
                pattern_q <= cfg_pattern;
                target_q  <= cfg_target;
                timeout_q <= cfg_timeout;
            end
            z    <= z_nxt;
            done <= done_nxt;
            if (start_ok) begin
                match_cnt <= '0;
                tmo_cnt   <= '0;
                tmo       <= 1'b0;
            end else begin
                if (cnt_en)
                    match_cnt <= sat_inc(match_cnt);
                if (busy)
                    tmo_cnt <= tmo_cnt_nxt;
                if (tmo_set)
                    tmo <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: stimulus queues expected z/done events,
// an independent negedge monitor pops and compares them.
module tb_seq_det_ctrl;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int TMO_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_we = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic [TMO_W-1:0] cfg_timeout = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             busy;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic             done;
    logic             tmo;

    typedef struct packed {
        logic             done;
        logic [CNT_W-1:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    int  checks = 0;
    int  errors = 0;

    seq_det_ctrl #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .TMO_W   (TMO_W),
        .RST_PAT (4'b0101)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .busy        (busy),
        .z           (z),
        .match_cnt   (match_cnt),
        .done        (done),
        .tmo         (tmo)
    );

    always #5 clk = ~clk;

    // Monitor: every z/done pulse must correspond to the oldest queued expectation.
    always @(negedge clk) begin
        if (z || done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got z=%0b done=%0b cnt=%0d, required no event",
                         z, done, match_cnt);
            end else begin
                mon_ev = exp_q.pop_front();
                if (z !== 1'b1 || done !== mon_ev.done || match_cnt !== mon_ev.cnt) begin
                    errors++;
                    $display("FAIL event: got z=%0b done=%0b cnt=%0d, required z=1 done=%0b cnt=%0d",
                             z, done, match_cnt, mon_ev.done, mon_ev.cnt);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic send(input logic b, input logic v);
        din       = b;
        din_valid = v;
        step();
        din       = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic exp_ev(input logic d, input logic [CNT_W-1:0] c);
        exp_q.push_back('{done: d, cnt: c});
    endtask

    task automatic drain(input string name);
        step();
        step();
        chk(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic start_run(input logic we, input logic [PAT_W-1:0] p,
                             input logic [CNT_W-1:0] t, input logic [TMO_W-1:0] to);
        cfg_we      = we;
        cfg_pattern = p;
        cfg_target  = t;
        cfg_timeout = to;
        start       = 1'b1;
        step();
        start  = 1'b0;
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gap_bits [6];
        gap_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values while reset is held
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        #10 reset = 1'b1;
        step();

        // Config and start on the same edge; then reset mid-run
        start_run(1'b1, 4'b0011, 8'd0, 16'd0);
        send(0, 1); send(0, 1); send(1, 1);
        exp_ev(1'b0, 8'd1);
        send(1, 1);
        send(0, 1); send(0, 1); send(1, 1);
        chk("cfgstart_busy", 32'(busy), 32'd1);
        chk("cfgstart_cnt", 32'(match_cnt), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_z", 32'(z), 32'd0);
        chk("midrst_cnt", 32'(match_cnt), 32'd0);
        chk("midrst_events", 32'(exp_q.size()), 32'd0);
        #2 reset = 1'b1;
        step();

        // Overlap with the reset pattern 0101
        start_run(1'b0, 4'b0000, 8'd0, 16'd0);
        send(0, 1); send(1, 1); send(0, 1);
        exp_ev(1'b0, 8'd1);
        send(1, 1);
        send(0, 1);
        exp_ev(1'b0, 8'd2);
        send(1, 1);
        drain("overlap_events");
        chk("overlap_cnt", 32'(match_cnt), 32'd2);
        chk("overlap_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt_held", 32'(match_cnt), 32'd2);

        // Target count ends the run
        start_run(1'b1, 4'b0110, 8'd2, 16'd0);
        send(0, 1); send(1, 1); send(1, 1);
        exp_ev(1'b0, 8'd1);
        send(0, 1);
        send(1, 1); send(1, 1);
        exp_ev(1'b1, 8'd2);
        send(0, 1);
        step();
        chk("target_busy", 32'(busy), 32'd0);
        chk("target_done_pulse", 32'(done), 32'd0);
        send(1, 1); send(1, 1); send(0, 1); send(1, 1); send(1, 1); send(0, 1);
        drain("target_no_more_events");
        chk("target_cnt", 32'(match_cnt), 32'd2);

        // Timeout after 10 busy cycles without a match
        start_run(1'b1, 4'b1111, 8'd0, 16'd10);
        repeat (9) send(0, 1);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        chk("tmo_before", 32'(tmo), 32'd0);
        send(0, 1);
        chk("tmo_busy_after", 32'(busy), 32'd0);
        chk("tmo_set", 32'(tmo), 32'd1);
        chk("tmo_done", 32'(done), 32'd0);

        // New start clears tmo; sparse valid stream gives the same matches as dense
        start_run(1'b1, 4'b0101, 8'd0, 16'd0);
        chk("tmo_cleared", 32'(tmo), 32'd0);
        for (int i = 0; i < 6; i++) begin
            send(~gap_bits[i], 0);
            if (i == 3 || i == 5)
                exp_ev(1'b0, CNT_W'((i + 1) / 2 - 1));
            send(gap_bits[i], 1);
        end
        drain("gaps_events");
        chk("gaps_cnt", 32'(match_cnt), 32'd2);
        send(0, 1);
        abort = 1'b1;
        send(1, 1);
        abort = 1'b0;
        chk("abort_match_busy", 32'(busy), 32'd0);
        chk("abort_match_done", 32'(done), 32'd0);
        chk("abort_match_cnt", 32'(match_cnt), 32'd2);
        drain("abort_match_no_event");

        // start and cfg_we during RUN are ignored
        start_run(1'b1, 4'b0011, 8'd0, 16'd0);
        send(0, 1); send(0, 1); send(1, 1);
        exp_ev(1'b0, 8'd1);
        send(1, 1);
        cfg_we      = 1'b1;
        cfg_pattern = 4'b1111;
        start       = 1'b1;
        send(1, 0);
        cfg_we = 1'b0;
        start  = 1'b0;
        send(0, 1); send(0, 1); send(1, 1);
        exp_ev(1'b0, 8'd2);
        send(1, 1);
        drain("ignored_ops_events");
        chk("ignored_ops_cnt", 32'(match_cnt), 32'd2);
        chk("ignored_ops_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Target reached on the timeout edge: done wins, tmo stays clear
        start_run(1'b1, 4'b0011, 8'd1, 16'd4);
        send(0, 1); send(0, 1); send(1, 1);
        exp_ev(1'b1, 8'd1);
        send(1, 1);
        step();
        chk("tie_busy", 32'(busy), 32'd0);
        chk("tie_tmo", 32'(tmo), 32'd0);
        drain("tie_events");

        // match_cnt saturates with unlimited target
        start_run(1'b1, 4'b0000, 8'd0, 16'd0);
        repeat (3) send(0, 1);
        for (int i = 1; i <= 260; i++) begin
            exp_ev(1'b0, CNT_W'((i > 255) ? 255 : i));
            send(0, 1);
        end
        drain("sat_events");
        chk("sat_cnt", 32'(match_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
